// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU among N_REQ requesters.
// Each operation runs IDLE (grant) -> EXEC (capture result) -> RESP (hold until accepted).
module alu_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [5*N_REQ-1:0] req_op,
  input  logic [W*N_REQ-1:0] req_a,
  input  logic [W*N_REQ-1:0] req_b,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [4:0]         alu_op,
  input  logic [W-1:0]       alu_out,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  idx_t             ptr_q, grant_q, win_idx, grant_next;
  logic             win_found, force_zero_q;
  logic [4:0]       win_op, alu_op_q;
  logic [W-1:0]     win_a, win_b;
  logic [W-1:0]     alu_a_q, alu_b_q, rsp_data_q;
  logic [CNT_W-1:0] done_cnt_q;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[idx_t'((32'(ptr_q) + i) % N_REQ)]) begin
        win_found = 1'b1;
        win_idx   = idx_t'((32'(ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (idx_t'(i) == win_idx) begin
        win_op = req_op[5*i +: 5];
        win_a  = req_a[W*i +: W];
        win_b  = req_b[W*i +: W];
      end
    end
  end

  assign grant_next = (grant_q == idx_t'(N_REQ - 1)) ? '0 : grant_q + idx_t'(1);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          state_d            = StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      grant_q      <= '0;
      force_zero_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 5'h01;
      rsp_data_q   <= '0;
      done_cnt_q   <= '0;
    end else begin
      if (state_q == StIdle && win_found) begin
        alu_a_q      <= win_a;
        alu_b_q      <= win_b;
        grant_q      <= win_idx;
        // The ALU holds its last value on NOP, so NOP runs as ADD with the result zeroed.
        force_zero_q <= (win_op == 5'h00);
        alu_op_q     <= (win_op == 5'h00) ? 5'h01 : win_op;
      end
      if (state_q == StExec) begin
        rsp_data_q <= force_zero_q ? '0 : alu_out;
      end
      if (state_q == StResp && rsp_ready[grant_q]) begin
        done_cnt_q <= done_cnt_q + CNT_W'(1);
        ptr_q      <= grant_next;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign done_cnt = done_cnt_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic checked against
// a transaction-level round-robin model; an ALU model closes the loop on alu_out.
module tb_alu_share_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [5*N-1:0]  req_op = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [31:0]   alu_a, alu_b, alu_out, rsp_data;
  logic [4:0]    alu_op;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready = '0;
  logic          busy;
  logic [15:0]   done_cnt;

  alu_share_arbiter #(.N_REQ(N), .W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  // Shared ALU; NOP returns a stale-looking value to stand in for "holds last result".
  function automatic logic [31:0] alu_fn(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      5'h00:   return 32'hDEADBEEF;
      5'h01:   return a + b;
      5'h02:   return a - b;
      5'h03:   return a & b;
      5'h04:   return a | b;
      5'h05:   return a ^ b;
      5'h06:   return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [31:0] expect_fn(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    return (op == 5'h00) ? 32'h0 : alu_fn(op, a, b);
  endfunction

  // Reference model: pending requests, pointer, phase of the current transaction.
  bit          pend [N];
  logic [4:0]  p_op [N];
  logic [31:0] p_a  [N];
  logic [31:0] p_b  [N];
  int          m_ptr = 0, m_grant = 0, m_state = 0;
  logic [4:0]  m_op;
  logic [31:0] m_exp;
  logic [15:0] m_done = '0;
  logic [N-1:0] rdy_drive = '1;
  int          grant_q[$];
  logic [31:0] data_q[$];
  int          checks = 0, passes = 0, fails = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int r, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    pend[r] = 1'b1;
    p_op[r] = op;
    p_a[r]  = a;
    p_b[r]  = b;
  endtask

  function automatic bit pend_any();
    for (int k = 0; k < N; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at edge+1, check at edge+2, advance to next edge+1.
  task automatic step();
    bit found;
    int w;
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = pend[k];
      req_op[5*k +: 5]   = p_op[k];
      req_a[32*k +: 32]  = p_a[k];
      req_b[32*k +: 32]  = p_b[k];
    end
    rsp_ready = rdy_drive;
    #1;
    case (m_state)
      0: begin
        check("busy_idle", busy, 0);
        check("done_cnt", done_cnt, m_done);
        found = 1'b0;
        w = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!found && pend[c]) begin
            found = 1'b1;
            w = c;
          end
        end
        check("req_ready", req_ready, found ? (1 << w) : 0);
        for (int k = 0; k < N; k++) if (req_ready[k]) grant_q.push_back(k);
        if (found) begin
          m_grant = w;
          m_op    = p_op[w];
          m_exp   = expect_fn(p_op[w], p_a[w], p_b[w]);
          pend[w] = 1'b0;
          m_state = 1;
        end
      end
      1: begin
        check("req_ready_exec", req_ready, 0);
        check("busy_exec", busy, 1);
        check("rsp_valid_exec", rsp_valid, 0);
        check("alu_op", alu_op, (m_op == 5'h00) ? 5'h01 : m_op);
        m_state = 2;
      end
      default: begin
        check("rsp_valid", rsp_valid, 1 << m_grant);
        check("rsp_data", rsp_data, m_exp);
        check("req_ready_resp", req_ready, 0);
        check("busy_resp", busy, 1);
        if (rdy_drive[m_grant]) begin
          data_q.push_back(rsp_data);
          m_done  = m_done + 16'd1;
          m_ptr   = (m_grant + 1) % N;
          m_state = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    rdy_drive = '1;
    while ((pend_any() || m_state != 0) && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic run_to_resp(int g);
    int n = 0;
    while (!(m_state == 2 && m_grant == g) && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_op", alu_op, 5'h01);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_done_cnt", done_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    m_state = 0;
    m_ptr   = 0;
    m_done  = '0;
  endtask

  initial begin
    logic [31:0] exp_data [4];
    logic [4:0]  op;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      p_op[k] = '0;
      p_a[k]  = '0;
      p_b[k]  = '0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request.
    set_req(0, 5'h01, 32'd7, 32'd5);
    drain();
    check("single_done", done_cnt, 1);
    check("single_data", data_q[0], 32'd12);

    // All four valid right after reset.
    do_reset();
    grant_q.delete();
    data_q.delete();
    set_req(0, 5'h02, 32'd3, 32'd5);
    set_req(1, 5'h03, 32'hF0F0F0F0, 32'hFF00FF00);
    set_req(2, 5'h06, 32'h0, 32'h0);
    set_req(3, 5'h05, 32'hAAAAAAAA, 32'hFFFFFFFF);
    drain();
    exp_data = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFFFFFFF, 32'h55555555};
    check("grant_count", grant_q.size(), 4);
    check("data_count", data_q.size(), 4);
    for (int k = 0; k < 4 && k < grant_q.size() && k < data_q.size(); k++) begin
      check("grant_order", grant_q[k], k);
      check("all4_data", data_q[k], exp_data[k]);
    end

    // Backpressure on requester 1; requester 1's rsp_ready low, others high (ignored).
    set_req(0, 5'h01, 32'd1, 32'd2);
    set_req(1, 5'h04, 32'h0F0F0000, 32'h000000F0);
    set_req(2, 5'h02, 32'd10, 32'd4);
    rdy_drive = 4'b1101;
    run_to_resp(1);
    repeat (5) step();
    drain();

    // NOP and undefined opcodes.
    data_q.delete();
    set_req(2, 5'h00, 32'd9, 32'd9);
    drain();
    set_req(3, 5'h1F, 32'd9, 32'd9);
    drain();
    check("nop_data", data_q[0], 0);
    check("undef_data", data_q[1], 0);

    // Wrap-around arithmetic.
    set_req(0, 5'h01, 32'h7FFFFFFF, 32'h1);
    set_req(1, 5'h02, 32'h80000000, 32'h1);
    drain();

    // Reset while a response is pending.
    set_req(2, 5'h01, 32'd100, 32'd23);
    rdy_drive = 4'b0000;
    run_to_resp(2);
    step();
    do_reset();
    rdy_drive = '1;
    grant_q.delete();
    set_req(1, 5'h01, 32'd1, 32'd1);
    set_req(3, 5'h01, 32'd2, 32'd2);
    set_req(0, 5'h01, 32'd3, 32'd3);
    drain();
    check("post_reset_first_grant", grant_q[0], 0);
    check("post_reset_done", done_cnt, 3);

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(3) == 0) begin
          if ($urandom_range(9) == 0) op = 5'($urandom_range(31, 7));
          else op = 5'($urandom_range(6, 0));
          set_req(r, op, $urandom, $urandom);
        end
      end
      rdy_drive = 4'($urandom);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
